// File: rtl/ab_seq_generator.sv
// ab_seq_generator: stimulus generator for the "status |-> a ##GAP b" handshake.
// Requests are queued over a valid/ready port. Each request produces one status+a beat,
// and b follows exactly GAP clocks after that beat.
// Optional feature macro: ERR_INJECT_EN adds the inject_err port, which suppresses the b
// of the beat issued at the same edge.
module ab_seq_generator #(
    parameter int unsigned GAP   = 2,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             en,
    output logic             status,
    output logic             a,
    output logic             b,
    output logic             idle,
    output logic [CNT_W-1:0] issued_cnt,
    output logic [CNT_W-1:0] done_cnt
`ifdef ERR_INJECT_EN
    ,
    input  logic             inject_err
`endif
);

    // Requests carry no payload, so the FIFO state is fully described by its occupancy.
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [CW-1:0]    count_q, count_d;
    logic [GAP-1:0]   sr_q, sr_d;
    logic             status_q, status_d;
    logic             b_q, b_d;
    logic [CNT_W-1:0] issued_q, issued_d;
    logic [CNT_W-1:0] done_q, done_d;
    logic             push, pop, issue_bit;

    // Ready and idle come straight from registered state.
    assign req_ready  = (count_q != CW'(DEPTH));
    assign idle       = (count_q == '0) && (sr_q == '0);
    assign status     = status_q;
    assign a          = status_q;
    assign b          = b_q;
    assign issued_cnt = issued_q;
    assign done_cnt   = done_q;

    // Next-state: push/pop accounting, beat issue, b scheduling and counters.
    always_comb begin
        push      = req_valid && req_ready;
        pop       = en && (count_q != '0);
        count_d   = count_q;
        issue_bit = pop;
`ifdef ERR_INJECT_EN
        // Only meaningful on an issue edge; otherwise there is nothing to corrupt.
        issue_bit = pop && !inject_err;
`endif
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        // Bit 0 holds the beat issued at this edge; the top bit becomes b one edge later.
        sr_d     = GAP'({sr_q, issue_bit});
        status_d = pop;
        b_d      = sr_q[GAP-1];
        issued_d = issued_q;
        done_d   = done_q;
        if (pop) begin
            issued_d = issued_q + CNT_W'(1);
        end
        if (sr_q[GAP-1]) begin
            done_d = done_q + CNT_W'(1);
        end
    end

    // State registers with synchronous reset; reset drops queued and in-flight beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            sr_q     <= '0;
            status_q <= 1'b0;
            b_q      <= 1'b0;
            issued_q <= '0;
            done_q   <= '0;
        end else begin
            count_q  <= count_d;
            sr_q     <= sr_d;
            status_q <= status_d;
            b_q      <= b_d;
            issued_q <= issued_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_ab_seq_generator.sv
// Testbench for ab_seq_generator: directed phases followed by randomized traffic, with
// the outputs compared against a queue-based reference model at every clock.
module tb_ab_seq_generator;

    localparam int unsigned GAP   = 2;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic             en;
    logic             status;
    logic             a;
    logic             b;
    logic             idle;
    logic [CNT_W-1:0] issued_cnt;
    logic [CNT_W-1:0] done_cnt;
`ifdef ERR_INJECT_EN
    logic             inject_err;
`endif

    always #5 clk = ~clk;

    ab_seq_generator #(.GAP(GAP), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .en         (en),
        .status     (status),
        .a          (a),
        .b          (b),
        .idle       (idle),
        .issued_cnt (issued_cnt),
        .done_cnt   (done_cnt)
`ifdef ERR_INJECT_EN
        ,
        .inject_err (inject_err)
`endif
    );

    // Reference model: queued request count plus a list of clock numbers at which b is due.
    int               n_assert = 0;
    int               n_fail   = 0;
    int               cyc      = 0;
    int               pending  = 0;
    int               due[$];
    logic             e_status = 1'b0;
    logic             e_b      = 1'b0;
    logic [CNT_W-1:0] e_iss    = '0;
    logic [CNT_W-1:0] e_done   = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s at clock %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Advance one clock, update the model from the inputs seen at that edge, then compare.
    task automatic tick();
        bit ready_pre;
        bit push;
        bit pop;
        bit lose_b;
        @(posedge clk);
        cyc++;
        if (rst) begin
            pending = 0;
            due.delete();
            e_status = 1'b0;
            e_b      = 1'b0;
            e_iss    = '0;
            e_done   = '0;
        end else begin
            ready_pre = (pending < int'(DEPTH));
            pop       = en && (pending > 0);
            push      = req_valid && ready_pre;
            pending   = pending + int'(push) - int'(pop);
            e_status  = pop;
            lose_b    = 1'b0;
`ifdef ERR_INJECT_EN
            lose_b = inject_err;
`endif
            if (pop) begin
                e_iss = e_iss + 1'b1;
                if (!lose_b) due.push_back(cyc + int'(GAP));
            end
            e_b = 1'b0;
            if (due.size() > 0 && due[0] == cyc) begin
                void'(due.pop_front());
                e_b    = 1'b1;
                e_done = e_done + 1'b1;
            end
        end
        #1;
        chk("status", 32'(status), 32'(e_status));
        chk("a", 32'(a), 32'(e_status));
        chk("b", 32'(b), 32'(e_b));
        chk("req_ready", 32'(req_ready), 32'(pending < int'(DEPTH)));
        chk("idle", 32'(idle), 32'(pending == 0 && due.size() == 0));
        chk("issued_cnt", 32'(issued_cnt), 32'(e_iss));
        chk("done_cnt", 32'(done_cnt), 32'(e_done));
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        en        = 1'b0;
`ifdef ERR_INJECT_EN
        inject_err = 1'b0;
`endif
        // Reset held for two clocks.
        tick();
        tick();
        chk("reset_idle", 32'(idle), 32'd1);
        chk("reset_ready", 32'(req_ready), 32'd1);
        rst = 1'b0;

        // Single request: a one clock after the push, b GAP clocks after a.
        en        = 1'b1;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        chk("single_a", 32'(a), 32'd1);
        repeat (GAP) tick();
        chk("single_b", 32'(b), 32'd1);
        repeat (3) tick();
        chk("single_issued", 32'(issued_cnt), 32'd1);
        chk("single_done", 32'(done_cnt), 32'd1);
        chk("single_idle", 32'(idle), 32'd1);

        // Burst of six with issue held off: FIFO fills and ready drops, then drains back-to-back.
        en        = 1'b0;
        req_valid = 1'b1;
        repeat (6) tick();
        chk("full_ready", 32'(req_ready), 32'd0);
        en = 1'b1;
        repeat (4) tick();
        req_valid = 1'b0;
        repeat (10) tick();

        // Pause: three queued, one issued, en low five clocks while its b completes, then resume.
        en        = 1'b0;
        req_valid = 1'b1;
        repeat (3) tick();
        req_valid = 1'b0;
        en        = 1'b1;
        tick();
        en = 1'b0;
        repeat (5) tick();
        en = 1'b1;
        repeat (6) tick();

        // Reset while beats are in flight: nothing survives.
        req_valid = 1'b1;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        chk("midrst_b", 32'(b), 32'd0);
        rst       = 1'b0;
        req_valid = 1'b0;
        repeat (GAP + 3) tick();
        chk("midrst_idle", 32'(idle), 32'd1);
        chk("midrst_done", 32'(done_cnt), 32'd0);

        // Saturated traffic long enough to wrap both counters.
        req_valid = 1'b1;
        en        = 1'b1;
        repeat (300) tick();

        // Randomized traffic with occasional resets.
        repeat (1500) begin
            req_valid = ($urandom_range(0, 9) < 7);
            en        = ($urandom_range(0, 9) < 6);
            rst       = ($urandom_range(0, 149) == 0);
`ifdef ERR_INJECT_EN
            inject_err = ($urandom_range(0, 7) == 0);
`endif
            tick();
        end
        rst       = 1'b0;
        req_valid = 1'b0;
        en        = 1'b1;
`ifdef ERR_INJECT_EN
        inject_err = 1'b0;
`endif
        repeat (DEPTH + GAP + 3) tick();
        chk("final_idle", 32'(idle), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
